// File: rtl/btn_cmd_sched.sv
// btn_cmd_sched
//   Command scheduler between the debounced push buttons and the alarm-clock
//   control logic. It turns held button levels into single-cycle command
//   pulses, lets one button own the command channel at a time, and produces
//   hold-to-auto-repeat pulses (first repeat after HOLD_TICKS, then every
//   REPEAT_TICKS cycles).
//
// Ports
//   CLK100HZ    in   100 Hz system tick clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   enable      in   low forces the scheduler idle with no commands
//   btn_in      in   N_BTN debounced button levels, active high
//   cmd_valid   out  single-cycle command strobe
//   cmd_id      out  index of the owning button (valid with cmd_valid)
//   cmd_repeat  out  0 = initial press, 1 = auto-repeat
//   busy        out  high while a button owns the channel
//   long_press  out  only with BTN_LONG_PRESS_EN defined: one-cycle pulse
//                    coincident with the first repeat pulse of a hold
//
// Optional feature macro: BTN_LONG_PRESS_EN
module btn_cmd_sched #(
  parameter int N_BTN        = 4,
  parameter int ID_W         = 2,
  parameter int HOLD_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter int CNT_W        = 8
) (
  input  logic             CLK100HZ,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_BTN-1:0] btn_in,
  output logic             cmd_valid,
  output logic [ID_W-1:0]  cmd_id,
  output logic             cmd_repeat,
  output logic             busy
`ifdef BTN_LONG_PRESS_EN
  ,
  output logic             long_press
`endif
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  state_t            state, state_nx;
  logic [ID_W-1:0]   owner, owner_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [N_BTN-1:0]  prev;
  logic [N_BTN-1:0]  rise;
  logic [ID_W-1:0]   first_idx;
  logic              owner_held;
  logic              fire, fire_repeat, first_repeat;
  logic              valid_nx, repeat_nx;
  logic [ID_W-1:0]   id_nx;
  logic              long_nx;

  assign rise       = btn_in & ~prev;
  assign owner_held = btn_in[owner];

  // Lowest set index of rise wins; scanning downwards lets the lowest overwrite.
  always_comb begin
    first_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (rise[i]) first_idx = ID_W'(i);
    end
  end

  // State register plus registered outputs. prev resets to all ones so that a
  // button already held when reset releases needs a fresh press to fire.
  always_ff @(posedge CLK100HZ or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      cnt        <= '0;
      prev       <= '1;
      cmd_valid  <= 1'b0;
      cmd_id     <= '0;
      cmd_repeat <= 1'b0;
      busy       <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
      long_press <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      cnt        <= cnt_nx;
      prev       <= btn_in;
      cmd_valid  <= valid_nx;
      cmd_id     <= id_nx;
      cmd_repeat <= repeat_nx;
      busy       <= (state_nx != IDLE);
`ifdef BTN_LONG_PRESS_EN
      long_press <= long_nx;
`endif
    end
  end

  // Next-state logic. Release is tested before the counter terminal count so
  // a release on the firing edge suppresses the pulse.
  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    cnt_nx       = cnt;
    fire         = 1'b0;
    fire_repeat  = 1'b0;
    first_repeat = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise != '0) begin
            owner_nx = first_idx;
            cnt_nx   = '0;
            state_nx = HOLD;
            fire     = 1'b1;
          end
        end
        HOLD: begin
          if (!owner_held) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt == HOLD_LAST) begin
            fire         = 1'b1;
            fire_repeat  = 1'b1;
            first_repeat = 1'b1;
            cnt_nx       = '0;
            state_nx     = REPEAT;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!owner_held) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt == REPEAT_LAST) begin
            fire        = 1'b1;
            fire_repeat = 1'b1;
            cnt_nx      = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Next output values; cmd_id and cmd_repeat hold between pulses.
  always_comb begin
    valid_nx  = fire;
    id_nx     = fire ? owner_nx : cmd_id;
    repeat_nx = fire ? fire_repeat : cmd_repeat;
    long_nx   = first_repeat;
  end

`ifndef BTN_LONG_PRESS_EN
  logic unused_long;
  assign unused_long = long_nx;
`endif

endmodule

// File: tb/tb_btn_cmd_sched.sv
// tb_btn_cmd_sched
//   Directed bench for btn_cmd_sched with HOLD_TICKS=10, REPEAT_TICKS=4,
//   N_BTN=4. Inputs change on the falling edge, outputs are sampled 1 time
//   unit after the rising edge that consumed them.
module tb_btn_cmd_sched;

  logic       CLK100HZ;
  logic       rst_n;
  logic       enable;
  logic [3:0] btn_in;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic       cmd_repeat;
  logic       busy;
`ifdef BTN_LONG_PRESS_EN
  logic       long_press;
`endif

  int checks = 0;
  int errors = 0;

  btn_cmd_sched #(
    .N_BTN(4), .ID_W(2), .HOLD_TICKS(10), .REPEAT_TICKS(4), .CNT_W(8)
  ) dut (
    .CLK100HZ  (CLK100HZ),
    .rst_n     (rst_n),
    .enable    (enable),
    .btn_in    (btn_in),
    .cmd_valid (cmd_valid),
    .cmd_id    (cmd_id),
    .cmd_repeat(cmd_repeat),
    .busy      (busy)
`ifdef BTN_LONG_PRESS_EN
    ,
    .long_press(long_press)
`endif
  );

  initial begin
    CLK100HZ = 1'b0;
    forever #5 CLK100HZ = ~CLK100HZ;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one sample on the falling edge and return just after the rising
  // edge that consumes it, so outputs reflect these inputs.
  task automatic applyStimulus(input logic [3:0] btn, input logic en);
    @(negedge CLK100HZ);
    btn_in = btn;
    enable = en;
    @(posedge CLK100HZ);
    #1;
  endtask

  task automatic expectIdle(input string tag);
    checkOutput({tag, "_valid"}, 32'(cmd_valid), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic expectPulse(input string tag, input int id, input int rpt);
    checkOutput({tag, "_valid"}, 32'(cmd_valid), 1);
    checkOutput({tag, "_id"}, 32'(cmd_id), 32'(id));
    checkOutput({tag, "_rpt"}, 32'(cmd_repeat), 32'(rpt));
    checkOutput({tag, "_busy"}, 32'(busy), 1);
  endtask

  // Hold a button for cycles 1..last after its initial pulse; repeats are
  // expected at offsets 10, 14, 18, ...
  task automatic holdAndCheck(input string tag, input logic [3:0] btn, input int id, input int last);
    int expV;
    for (int j = 1; j <= last; j++) begin
      applyStimulus(btn, 1'b1);
      expV = (j >= 10 && ((j - 10) % 4) == 0) ? 1 : 0;
      checkOutput({tag, "_valid"}, 32'(cmd_valid), 32'(expV));
      checkOutput({tag, "_busy"}, 32'(busy), 1);
      if (expV == 1) begin
        checkOutput({tag, "_id"}, 32'(cmd_id), 32'(id));
        checkOutput({tag, "_rpt"}, 32'(cmd_repeat), 1);
      end
`ifdef BTN_LONG_PRESS_EN
      checkOutput({tag, "_long"}, 32'(long_press), (j == 10) ? 1 : 0);
`endif
    end
  endtask

  initial begin
    // Reset with button 1 already held.
    rst_n  = 1'b1;
    enable = 1'b1;
    btn_in = 4'b0010;
    #2 rst_n = 1'b0;
    #5;
    checkOutput("rst_valid", 32'(cmd_valid), 0);
    checkOutput("rst_id", 32'(cmd_id), 0);
    checkOutput("rst_rpt", 32'(cmd_repeat), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    @(negedge CLK100HZ);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0010, 1'b1);
      expectIdle("held_at_reset");
    end
    applyStimulus(4'b0000, 1'b1);
    expectIdle("held_release");

    // Short press of button 2.
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0100, 1'b1);
    expectPulse("press2", 2, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0100, 1'b1);
      checkOutput("press2_hold_valid", 32'(cmd_valid), 0);
      checkOutput("press2_hold_busy", 32'(busy), 1);
      checkOutput("press2_hold_id", 32'(cmd_id), 2);
    end
    applyStimulus(4'b0000, 1'b1);
    expectIdle("press2_release");

    // Button 1 held for 30 cycles: repeats at 10,14,18,22,26.
    applyStimulus(4'b0010, 1'b1);
    expectPulse("long1", 1, 0);
    holdAndCheck("long1_hold", 4'b0010, 1, 29);
    applyStimulus(4'b0000, 1'b1);
    expectIdle("long1_release");
    checkOutput("long1_rpt_held", 32'(cmd_repeat), 1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b0000, 1'b1);
      expectIdle("long1_after");
    end

    // Simultaneous rise: lowest index wins; button 3 needs a fresh rise.
    applyStimulus(4'b1010, 1'b1);
    expectPulse("simul", 1, 0);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("simul_hold_valid", 32'(cmd_valid), 0);
    applyStimulus(4'b1000, 1'b1);
    expectIdle("simul_rel1");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1000, 1'b1);
      expectIdle("simul_b3_held");
    end
    applyStimulus(4'b0000, 1'b1);
    expectIdle("simul_b3_rel");
    applyStimulus(4'b1000, 1'b1);
    expectPulse("simul_b3_repress", 3, 0);
    applyStimulus(4'b0000, 1'b1);
    expectIdle("simul_b3_done");

    // Release on the edge the first repeat would fire suppresses it.
    applyStimulus(4'b1000, 1'b1);
    expectPulse("prio", 3, 0);
    for (int j = 1; j <= 9; j++) begin
      applyStimulus(4'b1000, 1'b1);
      checkOutput("prio_hold_valid", 32'(cmd_valid), 0);
    end
    applyStimulus(4'b0000, 1'b1);
    expectIdle("prio_release");

    // Release of owner with a new rise on another button at the same edge.
    applyStimulus(4'b0001, 1'b1);
    expectPulse("swap", 0, 0);
    applyStimulus(4'b0010, 1'b1);
    expectIdle("swap_edge");
    applyStimulus(4'b0010, 1'b1);
    expectIdle("swap_held");
    applyStimulus(4'b0000, 1'b1);

    // Enable drop while in REPEAT.
    applyStimulus(4'b0001, 1'b1);
    expectPulse("en", 0, 0);
    holdAndCheck("en_hold", 4'b0001, 0, 11);
    applyStimulus(4'b0001, 1'b0);
    expectIdle("en_low");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b0001, 1'b1);
      expectIdle("en_back_held");
    end
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0001, 1'b1);
    expectPulse("en_repress", 0, 0);
    applyStimulus(4'b0000, 1'b1);

    // A rise while disabled is not serviced, even after enable returns.
    applyStimulus(4'b0100, 1'b0);
    expectIdle("dis_rise");
    applyStimulus(4'b0100, 1'b1);
    expectIdle("dis_then_en");
    applyStimulus(4'b0000, 1'b1);

    // Asynchronous reset during REPEAT.
    applyStimulus(4'b0100, 1'b1);
    expectPulse("arst", 2, 0);
    holdAndCheck("arst_hold", 4'b0100, 2, 11);
    @(negedge CLK100HZ);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 0);
    checkOutput("arst_id", 32'(cmd_id), 0);
    checkOutput("arst_rpt", 32'(cmd_repeat), 0);
    checkOutput("arst_valid", 32'(cmd_valid), 0);
    @(negedge CLK100HZ);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0100, 1'b1);
      expectIdle("arst_held");
    end
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0100, 1'b1);
    expectPulse("arst_repress", 2, 0);
    applyStimulus(4'b0000, 1'b1);
    expectIdle("arst_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
